// File: rtl/grid_mover.sv
// grid_mover: owns the player tile coordinate. It steps the position on key presses
// and auto-repeats held keys. It either clamps or wraps at the map edges, and it can
// ask the collision logic whether the target tile is free before each step.
module grid_mover #(
  parameter int unsigned MAP_WIDTH    = 16,
  parameter int unsigned MAP_HEIGHT   = 16,
  parameter int unsigned COORD_W      = 4,
  parameter int unsigned INIT_X       = 0,
  parameter int unsigned INIT_Y       = 0,
  parameter int unsigned WRAP_MODE    = 0,
  parameter int unsigned USE_BLOCK    = 1,
  parameter int unsigned REPEAT_DELAY = 25,
  parameter int unsigned REPEAT_RATE  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         move,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic               blk_ack,
  input  logic               blk_hit,
  output logic               blk_req,
  output logic [COORD_W-1:0] blk_x,
  output logic [COORD_W-1:0] blk_y,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [3:0]         allow,
  output logic               moved,
  output logic               bumped,
  output logic               busy
);

  localparam int unsigned CntMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [COORD_W-1:0] XMax      = COORD_W'(MAP_WIDTH - 1);
  localparam logic [COORD_W-1:0] YMax      = COORD_W'(MAP_HEIGHT - 1);
  localparam logic [CntW-1:0]    DelayLoad = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0]    RateLoad  = CntW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {StIdle, StQuery, StHold} state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [COORD_W-1:0] blk_x_q, blk_x_d, blk_y_q, blk_y_d;
  logic [3:0]         prev_q, prev_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               moved_q, moved_d, bumped_q, bumped_d;

  logic [3:0]         dir;
  logic [3:0]         edge_ok;
  logic [COORD_W-1:0] tgt_x, tgt_y;
  logic               in_bounds;
  logic               launch;
  logic [CntW-1:0]    launch_cnt;

  // One-hot direction from the lowest set key bit (left > down > up > right).
  always_comb begin
    dir = 4'b0000;
    if (move[0])      dir = 4'b0001;
    else if (move[1]) dir = 4'b0010;
    else if (move[2]) dir = 4'b0100;
    else if (move[3]) dir = 4'b1000;
  end

  // Edge permission per direction and the candidate target tile (wrapped form).
  always_comb begin
    edge_ok[0] = (pos_x_q != '0);
    edge_ok[1] = (pos_y_q != YMax);
    edge_ok[2] = (pos_y_q != '0);
    edge_ok[3] = (pos_x_q != XMax);
    tgt_x = pos_x_q;
    tgt_y = pos_y_q;
    case (dir)
      4'b0001: tgt_x = (pos_x_q == '0)   ? XMax : pos_x_q - COORD_W'(1);
      4'b0010: tgt_y = (pos_y_q == YMax) ? '0   : pos_y_q + COORD_W'(1);
      4'b0100: tgt_y = (pos_y_q == '0)   ? YMax : pos_y_q - COORD_W'(1);
      4'b1000: tgt_x = (pos_x_q == XMax) ? '0   : pos_x_q + COORD_W'(1);
      default: ;
    endcase
    in_bounds = (WRAP_MODE != 0) || ((dir & edge_ok) != 4'b0000);
  end

  // Next-state logic: press/repeat detection, launch handling, query completion, load.
  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    blk_x_d    = blk_x_q;
    blk_y_d    = blk_y_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    moved_d    = 1'b0;
    bumped_d   = 1'b0;
    launch     = 1'b0;
    launch_cnt = DelayLoad;

    unique case (state_q)
      StIdle: begin
        prev_d = dir;
        if (dir != 4'b0000 && dir != prev_q) launch = 1'b1;
      end
      StHold: begin
        prev_d = dir;
        if (dir == 4'b0000) begin
          state_d = StIdle;
        end else if (dir != prev_q) begin
          launch = 1'b1;
        end else if (cnt_q == '0) begin
          launch     = 1'b1;
          launch_cnt = RateLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StQuery: begin
        if (blk_ack) begin
          state_d = StHold;
          if (blk_hit) begin
            bumped_d = 1'b1;
          end else begin
            pos_x_d = blk_x_q;
            pos_y_d = blk_y_q;
            moved_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // The counter value chosen at launch survives a query, so repeats keep their rate.
    if (launch) begin
      cnt_d = launch_cnt;
      if (!in_bounds) begin
        bumped_d = 1'b1;
        state_d  = StHold;
      end else if (USE_BLOCK == 0) begin
        pos_x_d = tgt_x;
        pos_y_d = tgt_y;
        moved_d = 1'b1;
        state_d = StHold;
      end else begin
        blk_x_d = tgt_x;
        blk_y_d = tgt_y;
        state_d = StQuery;
      end
    end

    // Reposition overrides everything; latching dir stops a held key re-triggering.
    if (load) begin
      pos_x_d  = (load_x > XMax) ? XMax : load_x;
      pos_y_d  = (load_y > YMax) ? YMax : load_y;
      state_d  = StIdle;
      prev_d   = dir;
      moved_d  = 1'b0;
      bumped_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pos_x_q  <= COORD_W'(INIT_X);
      pos_y_q  <= COORD_W'(INIT_Y);
      blk_x_q  <= '0;
      blk_y_q  <= '0;
      prev_q   <= 4'b0000;
      cnt_q    <= '0;
      moved_q  <= 1'b0;
      bumped_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      blk_x_q  <= blk_x_d;
      blk_y_q  <= blk_y_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      moved_q  <= moved_d;
      bumped_q <= bumped_d;
    end
  end

  assign blk_req = (state_q == StQuery);
  assign busy    = (state_q == StQuery);
  assign blk_x   = blk_x_q;
  assign blk_y   = blk_y_q;
  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign allow   = (WRAP_MODE != 0) ? 4'b1111 : edge_ok;
  assign moved   = moved_q;
  assign bumped  = bumped_q;

endmodule
